mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Parametrised Y86 memory-stage controller between the execute and write-back stages. Selects the data-memory address and write data from the instruction code, drives a request/acknowledge data-memory port with a wait-state timeout and bounds check, and computes the instruction status (AOK/HLT/ADR/INS). It is a single-entry buffered stage with valid/ready handshakes on both sides, and latches a sticky halt once a non-AOK status has been handed to write-back.

## Interface
- DATA_WID, 32: width of valE/valA/valP/valM and the memory data bus.
- MADDR_WID, 32: width of the memory address.
- ADDR_LIMIT, 1024: size of the valid byte address space; an access is legal iff addr + DATA_WID/8 <= ADDR_LIMIT.
- TIMEOUT, 15: maximum number of cycles to wait for mem_ack before aborting with ADR; must be >= 1.
- One clock; reset is asynchronous and active-low.
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute stage offers an instruction.
- in_ready  out  1  stage accepts; high iff state is IDLE.
- in_icode  in  4  instruction code.
- in_stat  in  4  status from earlier stages.
- in_valE / in_valA / in_valP  in  DATA_WID each  execute results.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  write enable; qualified by mem_req.
- mem_addr  out  MADDR_WID  byte address.
- mem_wdata  out  DATA_WID  write data.
- mem_ack  in  1  one-cycle response pulse.
- mem_rdata  in  DATA_WID  read data; valid with mem_ack.
- mem_err  in  1  memory fault; valid with mem_ack.
- out_valid  out  1  result available to write-back.
- out_ready  in  1  write-back accepts.
- out_icode  out  4; out_valE, out_valM  out  DATA_WID; out_stat  out  4.
- busy  out  1  high in ACCESS (for the hazard/stall unit).
- halted  out  1  sticky halt flag.

## Operation
- Decode, as a pure function of icode:
  - Address: valE for RMMOV/PUSH/CALL/MRMOV; valA for POP/RET.
  - Write data: valA for RMMOV/PUSH; valP for CALL.
  - Read: MRMOV/RET/POP.
  - Write: RMMOV/PUSH/CALL.
- FSM states:
  - IDLE: on in_valid, capture all inputs, then:
    - If in_stat != AOK, or icode is not a memory op: go to RESP. out_stat = in_stat, except icode HALT with in_stat AOK gives HLT.
    - Else if the address is out of bounds: go to RESP with out_stat = ADR. No request is issued.
    - Else go to ACCESS.
  - ACCESS: mem_req=1, mem_we=write, address and data stable. The wait counter increments every cycle without mem_ack.
    - On mem_ack: out_valM = mem_rdata on reads (0 on writes); out_stat = ADR if mem_err, else AOK. Go to RESP.
    - If the counter reaches TIMEOUT: drop mem_req, out_stat = ADR, go to RESP.
    - A mem_ack arriving in the timeout cycle wins.
  - RESP: out_valid=1 with all outputs held stable until out_ready. On transfer, go to IDLE if out_stat == AOK, else to HALTED.
  - HALTED: halted=1, in_ready=0, mem_req=0. Leaves only on reset.
- out_valE = captured valE; out_icode = captured icode.

## Timing
- Reset values: state IDLE; mem_req/mem_we/out_valid/busy/halted = 0; addresses and data = 0; out_stat = AOK (4'h1). in_ready = 1 after reset release.
- All outputs are registered except in_ready, which decodes directly from state.
- Non-memory op: accepted at edge T, out_valid high from T+1.
- Memory op: mem_req high from T+1. An ack sampled at edge T+1+k gives out_valid from T+2+k.
- Throughput: at most one instruction per two cycles.
- Timeout: mem_req is low and out_valid high at T+2+TIMEOUT.
- Reset mid-ACCESS drops mem_req immediately (asynchronous); any later mem_ack is ignored.
- mem_ack outside ACCESS is ignored.

## Structure
- The shared head package holds: icode constants (HALT=0, NOP=1, ..., CALL=8, RET=9, PUSH=A, POP=B); stat codes AOK=1, HLT=2, ADR=3, INS=4; ICODE_WID=4.
- Sub-module mem_op_decode is combinational and produces addr_sel, data_sel, read and write from icode.
- The FSM, wait counter (width clog2(TIMEOUT+1)) and output registers live in the top module.

## Test plan
- NOP then IRMOV, in_stat AOK, out_ready=1 -> no mem_req; out_valid one cycle after each accept; out_stat=1.
- MRMOV valE=0x40, memory acks after 3 cycles with rdata 0xDEADBEEF -> mem_addr=0x40, mem_we=0; out_valM=0xDEADBEEF, stat AOK.
- CALL valE=0x3FC, valP=0x123 -> mem_we=1, mem_wdata=0x123. Then PUSH valE=0x3FE -> no request, out_stat=ADR, halted after transfer, in_ready stays 0.
- POP valA=0x10, memory never acks, TIMEOUT=15 -> mem_req drops after 15 cycles, out_stat=ADR. An ack arriving in the 15th cycle gives AOK instead.
- HALT with in_stat AOK, and RMMOV with in_stat INS -> out_stat HLT and INS respectively, no memory access, halted afterwards.
- rst_n pulsed low mid-ACCESS, then a late mem_ack -> mem_req=0 asynchronously, outputs at reset values, late ack ignored, next instruction accepted normally.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared Y86 memory-stage definitions: instruction codes, status codes,
// FSM states and the decode select encodings.
package mem_stage_ctrl_pkg;

    localparam int ICODE_WID = 4;
    localparam int STAT_WID  = 4;

    typedef logic [ICODE_WID-1:0] icode_t;
    typedef logic [STAT_WID-1:0]  stat_t;

    localparam icode_t I_HALT  = 4'h0;
    localparam icode_t I_NOP   = 4'h1;
    localparam icode_t I_RRMOV = 4'h2;
    localparam icode_t I_IRMOV = 4'h3;
    localparam icode_t I_RMMOV = 4'h4;
    localparam icode_t I_MRMOV = 4'h5;
    localparam icode_t I_OPQ   = 4'h6;
    localparam icode_t I_JXX   = 4'h7;
    localparam icode_t I_CALL  = 4'h8;
    localparam icode_t I_RET   = 4'h9;
    localparam icode_t I_PUSH  = 4'hA;
    localparam icode_t I_POP   = 4'hB;

    localparam stat_t STAT_AOK = 4'h1;
    localparam stat_t STAT_HLT = 4'h2;
    localparam stat_t STAT_ADR = 4'h3;
    localparam stat_t STAT_INS = 4'h4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_HALTED
    } state_e;

    typedef enum logic {
        ASEL_VALE,
        ASEL_VALA
    } addr_sel_e;

    typedef enum logic [1:0] {
        DSEL_NONE,
        DSEL_VALA,
        DSEL_VALP
    } data_sel_e;

    function automatic logic stat_is_ok(input stat_t s);
        return s == STAT_AOK;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_decode.sv
// Memory-op decode: address/data source and direction from the icode alone.
// Latency: combinational. Backpressure: none (pure function).
// Non-memory icodes decode to no read, no write, valE address, no data.
module mem_op_decode
    import mem_stage_ctrl_pkg::*;
(
    input  logic [ICODE_WID-1:0] icode,
    output addr_sel_e            addr_sel,
    output data_sel_e            data_sel,
    output logic                 read,
    output logic                 write
);

    always_comb begin
        addr_sel = ASEL_VALE;
        data_sel = DSEL_NONE;
        read     = 1'b0;
        write    = 1'b0;
        case (icode)
            I_RMMOV, I_PUSH: begin
                write    = 1'b1;
                data_sel = DSEL_VALA;
            end
            I_CALL: begin
                write    = 1'b1;
                data_sel = DSEL_VALP;
            end
            I_MRMOV: begin
                read = 1'b1;
            end
            // Stack pops read from the old stack pointer carried in valA.
            I_POP, I_RET: begin
                read     = 1'b1;
                addr_sel = ASEL_VALA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Y86 memory stage: single-entry buffer driving a req/ack data-memory port.
// Latency: 1 cycle for non-memory ops, 2+k cycles for an ack after k waits.
// Backpressure: in_ready only in IDLE; result held in RESP until out_ready.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DATA_WID   = 32,
    parameter int MADDR_WID  = 32,
    parameter int ADDR_LIMIT = 1024,
    parameter int TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ICODE_WID-1:0] in_icode,
    input  logic [STAT_WID-1:0]  in_stat,
    input  logic [DATA_WID-1:0]  in_valE,
    input  logic [DATA_WID-1:0]  in_valA,
    input  logic [DATA_WID-1:0]  in_valP,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [MADDR_WID-1:0] mem_addr,
    output logic [DATA_WID-1:0]  mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_WID-1:0]  mem_rdata,
    input  logic                 mem_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ICODE_WID-1:0] out_icode,
    output logic [DATA_WID-1:0]  out_valE,
    output logic [DATA_WID-1:0]  out_valM,
    output logic [STAT_WID-1:0]  out_stat,
    output logic                 busy,
    output logic                 halted
);

    localparam int CNT_WID = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int AEXT_WID = MADDR_WID + 1;
    localparam logic [CNT_WID-1:0]  CNT_MAX   = CNT_WID'(TIMEOUT);
    localparam logic [AEXT_WID-1:0] LIMIT_EXT = AEXT_WID'(ADDR_LIMIT);
    localparam logic [AEXT_WID-1:0] BYTES_EXT = AEXT_WID'(DATA_WID / 8);

    state_e                 state_q, state_d;
    logic [CNT_WID-1:0]     cnt_q, cnt_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [MADDR_WID-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WID-1:0]    mem_wdata_q, mem_wdata_d;
    logic                   out_valid_q, out_valid_d;
    logic [ICODE_WID-1:0]   out_icode_q, out_icode_d;
    logic [DATA_WID-1:0]    out_vale_q, out_vale_d;
    logic [DATA_WID-1:0]    out_valm_q, out_valm_d;
    logic [STAT_WID-1:0]    out_stat_q, out_stat_d;
    logic                   busy_q, busy_d;
    logic                   halted_q, halted_d;

    addr_sel_e              addr_sel;
    data_sel_e              data_sel;
    logic                   op_read;
    logic                   op_write;
    logic                   op_is_mem;
    logic [DATA_WID-1:0]    acc_addr_raw;
    logic [MADDR_WID-1:0]   acc_addr;
    logic [DATA_WID-1:0]    acc_wdata;
    logic                   addr_ok;

    mem_op_decode u_decode (
        .icode    (in_icode),
        .addr_sel (addr_sel),
        .data_sel (data_sel),
        .read     (op_read),
        .write    (op_write)
    );

    always_comb begin
        acc_addr_raw = (addr_sel == ASEL_VALA) ? in_valA : in_valE;
        acc_addr     = MADDR_WID'(acc_addr_raw);
        case (data_sel)
            DSEL_VALA: acc_wdata = in_valA;
            DSEL_VALP: acc_wdata = in_valP;
            default:   acc_wdata = '0;
        endcase
        op_is_mem = op_read | op_write;
        // One extra address bit so a near-top address cannot wrap into range.
        addr_ok   = ({1'b0, acc_addr} + BYTES_EXT) <= LIMIT_EXT;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        out_icode_d = out_icode_q;
        out_vale_d  = out_vale_q;
        out_valm_d  = out_valm_q;
        out_stat_d  = out_stat_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    out_icode_d = in_icode;
                    out_vale_d  = in_valE;
                    out_valm_d  = '0;
                    cnt_d       = '0;
                    if (!stat_is_ok(in_stat) || !op_is_mem) begin
                        out_stat_d = (stat_is_ok(in_stat) && in_icode == I_HALT)
                                     ? STAT_HLT : in_stat;
                        state_d    = S_RESP;
                    end else if (!addr_ok) begin
                        out_stat_d = STAT_ADR;
                        state_d    = S_RESP;
                    end else begin
                        mem_addr_d  = acc_addr;
                        mem_wdata_d = acc_wdata;
                        mem_we_d    = op_write;
                        out_stat_d  = STAT_AOK;
                        state_d     = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // An ack in the final wait cycle takes priority over the abort.
                if (mem_ack) begin
                    out_valm_d = mem_we_q ? '0 : mem_rdata;
                    out_stat_d = mem_err ? STAT_ADR : STAT_AOK;
                    state_d    = S_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    out_stat_d = STAT_ADR;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WID'(1);
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = stat_is_ok(out_stat_q) ? S_IDLE : S_HALTED;
                end
            end
            S_HALTED: ;
            default: state_d = S_IDLE;
        endcase

        mem_req_d   = (state_d == S_ACCESS);
        busy_d      = (state_d == S_ACCESS);
        out_valid_d = (state_d == S_RESP);
        halted_d    = (state_d == S_HALTED);
        if (state_d != S_ACCESS) begin
            mem_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_icode_q <= '0;
            out_vale_q  <= '0;
            out_valm_q  <= '0;
            out_stat_q  <= STAT_AOK;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            out_valid_q <= out_valid_d;
            out_icode_q <= out_icode_d;
            out_vale_q  <= out_vale_d;
            out_valm_q  <= out_valm_d;
            out_stat_q  <= out_stat_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = out_valid_q;
    assign out_icode = out_icode_q;
    assign out_valE  = out_vale_q;
    assign out_valM  = out_valm_q;
    assign out_stat  = out_stat_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule
